aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_rcon_gen.sv | 37 +++
 rtl/aes_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller: FSM state encoding,
// default round count, first round constant and the GF(2^8) xtime helper.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SUB   = 3'd2,
        S_SHIFT = 3'd3,
        S_MIX   = 3'd4,
        S_ARK   = 3'd5,
        S_DONE  = 3'd6
    } aes_state_e;

    localparam int          AES_NR        = 10;
    localparam logic [7:0]  AES_RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads the first constant on reset or a new block,
// and steps by xtime once per key-expansion advance.
module aes_rcon_gen
    import aes_pkg::*;
#(
    parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (adv_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: LOAD, then SUB/SHIFT/MIX/ARK per round with MIX
// skipped in the last round. Define AES_ROUND_CTRL_ABORT_EN for the abort/aborted ports.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int         NR        = AES_NR,
    parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       ready,
    output logic       ld_state,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       key_en,
    output logic [7:0] rcon,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done,
    output aes_state_e state_dbg
);

    localparam logic [3:0] NR_L = 4'(NR);

    aes_state_e state_q;
    logic [3:0] round_q;
    logic       ld_q, sub_q, shift_q, mix_q, ark_q, key_q, done_q;
    logic       start_acc;
    logic       abort_req;

    assign start_acc = start && (state_q == S_IDLE);

`ifdef AES_ROUND_CTRL_ABORT_EN
    logic aborted_q;

    assign abort_req = abort && (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // Enables are registered alongside the state so each is high exactly while
    // the FSM sits in the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            ld_q    <= 1'b0;
            sub_q   <= 1'b0;
            shift_q <= 1'b0;
            mix_q   <= 1'b0;
            ark_q   <= 1'b0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ld_q    <= 1'b0;
            sub_q   <= 1'b0;
            shift_q <= 1'b0;
            mix_q   <= 1'b0;
            ark_q   <= 1'b0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        state_q <= S_LOAD;
                        round_q <= 4'd0;
                        ld_q    <= 1'b1;
                        ark_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_SUB;
                    round_q <= 4'd1;
                    sub_q   <= 1'b1;
                    key_q   <= 1'b1;
                end
                S_SUB: begin
                    state_q <= S_SHIFT;
                    shift_q <= 1'b1;
                end
                S_SHIFT: begin
                    if (round_q == NR_L) begin
                        state_q <= S_ARK;
                        ark_q   <= 1'b1;
                    end else begin
                        state_q <= S_MIX;
                        mix_q   <= 1'b1;
                    end
                end
                S_MIX: begin
                    state_q <= S_ARK;
                    ark_q   <= 1'b1;
                end
                S_ARK: begin
                    if (round_q < NR_L) begin
                        state_q <= S_SUB;
                        round_q <= round_q + 4'd1;
                        sub_q   <= 1'b1;
                        key_q   <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    round_q <= 4'd0;
                end
            endcase
            // Abort overrides whatever the case above scheduled.
            if (abort_req) begin
                state_q <= S_IDLE;
                round_q <= 4'd0;
                ld_q    <= 1'b0;
                sub_q   <= 1'b0;
                shift_q <= 1'b0;
                mix_q   <= 1'b0;
                ark_q   <= 1'b0;
                key_q   <= 1'b0;
                done_q  <= 1'b0;
            end
        end
    end

    aes_rcon_gen #(
        .RCON_INIT(RCON_INIT)
    ) u_rcon (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_acc || abort_req),
        .adv_i  (key_q),
        .rcon_o (rcon)
    );

    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign ld_state  = ld_q;
    assign sub_en    = sub_q;
    assign shift_en  = shift_q;
    assign mix_en    = mix_q;
    assign ark_en    = ark_q;
    assign key_en    = key_q;
    assign done      = done_q;
    assign round_idx = round_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: round timing, enable counts, rcon
// sequence, ignored starts, mid-run reset, back-to-back runs and optional abort.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ready, ld_state, sub_en, shift_en, mix_en, ark_en, key_en;
    logic [7:0] rcon;
    logic [3:0] round_idx;
    logic       busy, done;
    aes_state_e state_dbg;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    logic [7:0] exp_q[$];
    logic [3:0] exp_r_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .ready     (ready),
        .ld_state  (ld_state),
        .sub_en    (sub_en),
        .shift_en  (shift_en),
        .mix_en    (mix_en),
        .ark_en    (ark_en),
        .key_en    (key_en),
        .rcon      (rcon),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    task automatic push_exp();
        logic [7:0] tbl [10];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(tbl[i]);
            exp_r_q.push_back(4'(i + 1));
        end
    endtask

    // Presents start at a negedge and returns just after the accepting edge.
    task automatic start_run(input bit hold, input bit push);
        @(negedge clk);
        start = 1'b1;
        if (push) push_exp();
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Follows one run from the LOAD cycle (cycle 1) until done or the budget runs out.
    task automatic track_run(input string tag, input int glitch_cyc, output int done_cyc);
        int n_ld = 0, n_sub = 0, n_shift = 0, n_mix = 0, n_ark = 0, n_key = 0;
        bit excl_ok = 1'b1;
        logic [7:0] er;
        logic [3:0] eri;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if (!(ld_state === 1'b1 && ark_en === 1'b1 && round_idx === 4'd0 && busy === 1'b1)) begin
                    errors++;
                    $display("FAIL %s load_cycle: ld=%b ark=%b round=%0d busy=%b, need 1 1 0 1",
                             tag, ld_state, ark_en, round_idx, busy);
                end
            end
            n_ld    += int'(ld_state);
            n_sub   += int'(sub_en);
            n_shift += int'(shift_en);
            n_mix   += int'(mix_en);
            n_ark   += int'(ark_en);
            n_key   += int'(key_en);
            if ((int'(ld_state) + int'(sub_en) + int'(shift_en) + int'(mix_en) + int'(ark_en)) > 1 &&
                !(ld_state && ark_en && !sub_en && !shift_en && !mix_en)) excl_ok = 1'b0;
            if (mix_en && round_idx == 4'd10) excl_ok = 1'b0;
            if (key_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s rcon_extra: key_en in cycle %0d with no round expected", tag, cyc);
                end else begin
                    er  = exp_q.pop_front();
                    eri = exp_r_q.pop_front();
                    if (rcon !== er || round_idx !== eri || sub_en !== 1'b1) begin
                        errors++;
                        $display("FAIL %s rcon_seq: rcon=%h round=%0d sub=%b, need %h %0d 1",
                                 tag, rcon, round_idx, sub_en, er, eri);
                    end
                end
            end
            if (glitch_cyc != 0 && cyc == glitch_cyc) start = 1'b1;
            else if (glitch_cyc != 0 && cyc == glitch_cyc + 1) start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        if (done_cyc != 41) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, need 41", tag, done_cyc);
        end
        checks++;
        if (n_ld != 1 || n_sub != 10 || n_shift != 10 || n_mix != 9 || n_ark != 11 || n_key != 10) begin
            errors++;
            $display("FAIL %s enable_counts: ld=%0d sub=%0d shift=%0d mix=%0d ark=%0d key=%0d, need 1 10 10 9 11 10",
                     tag, n_ld, n_sub, n_shift, n_mix, n_ark, n_key);
        end
        checks++;
        if (!excl_ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s exclusivity: excl_ok=%b leftover_rounds=%0d, need 1 0", tag, excl_ok, exp_q.size());
        end
        exp_q.delete();
        exp_r_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd0 || rcon !== 8'h01 ||
            ld_state !== 1'b0 || sub_en !== 1'b0 || shift_en !== 1'b0 || mix_en !== 1'b0 ||
            ark_en !== 1'b0 || key_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b done=%b round=%0d rcon=%h en=%b%b%b%b%b%b, need 1 0 0 0 01 000000",
                     ready, busy, done, round_idx, rcon, ld_state, sub_en, shift_en, mix_en, ark_en, key_en);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b, need 1 0", ready, busy);
        end
    endtask

    task automatic test_single_run();
        int dc;
        start_run(1'b0, 1'b1);
        track_run("single", 0, dc);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after_done: done=%b ready=%b busy=%b, need 0 1 0", done, ready, busy);
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        int extra_done = 0;
        int extra_busy = 0;
        start_run(1'b0, 1'b1);
        track_run("ignore", 5, dc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            extra_done += int'(done);
            extra_busy += int'(busy);
        end
        checks++;
        if (extra_done != 0 || extra_busy != 0) begin
            errors++;
            $display("FAIL ignore_second_run: extra done=%0d busy_cycles=%0d, need 0 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        bit found = 1'b0;
        start_run(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ark_en === 1'b1 && round_idx === 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_find: round 4 ARK not seen, need it");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1 || round_idx !== 4'd0 || rcon !== 8'h01 ||
            ark_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b ready=%b round=%0d rcon=%h ark=%b done=%b, need 0 1 0 01 0 0",
                     busy, ready, round_idx, rcon, ark_en, done);
        end
        @(negedge clk);
        rst = 1'b0;
        start_run(1'b0, 1'b1);
        track_run("after_reset", 0, dc);
    endtask

    task automatic test_back_to_back();
        int dc;
        start_run(1'b1, 1'b1);
        track_run("b2b_first", 0, dc);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || ld_state !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: cycle 42 ready=%b busy=%b ld=%b, need 1 0 0", ready, busy, ld_state);
        end
        push_exp();
        @(posedge clk);
        #1 start = 1'b0;
        track_run("b2b_second", 0, dc);
    endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
    task automatic test_abort();
        bit found = 1'b0;
        int extra_done = 0;
        start_run(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (shift_en === 1'b1 && round_idx === 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_find: round 7 SHIFT not seen, need it");
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (aborted !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            round_idx !== 4'd0 || rcon !== 8'h01) begin
            errors++;
            $display("FAIL abort_outputs: aborted=%b ready=%b busy=%b done=%b round=%0d rcon=%h, need 1 1 0 0 0 01",
                     aborted, ready, busy, done, round_idx, rcon);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            extra_done += int'(done) + int'(aborted);
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("FAIL abort_after: late done/aborted pulses=%0d, need 0", extra_done);
        end
    endtask
`endif

    initial begin
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_single_run();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_ROUND_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
